fifo_uart_tx: RTL and testbench

Serial transmit stage downstream of the fifo block: drains words from the FIFO read port and shifts each one out as an asynchronous UART frame (start, data LSB-first, stop).
Sits between the transmit FIFO and the device pin.
Shares the FIFO's clk, reset and clk_en, so both stall together.

---
 rtl/fifo_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a transmit FIFO: start bit, DATA_WIDTH bits LSB first, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  fifo_r_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                state, state_next;
  logic [BAUD_W-1:0]     baud_cnt, baud_next;
  logic [BIT_W-1:0]      bit_cnt, bit_next;
  logic [DATA_WIDTH-1:0] shift_q, shift_next;
  logic                  bit_end;
  logic                  tx_next;
  logic                  frame_done_next;

`ifdef UART_TX_PARITY_EN
  logic parity_q;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_cnt;
    shift_next = shift_q;
    bit_end    = (baud_cnt == BAUD_LAST);

    case (state)
      S_IDLE:  if (!fifo_r_empty) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD: begin
        shift_next = fifo_r_data;
        baud_next  = '0;
        bit_next   = '0;
        state_next = S_START;
      end
      S_START: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = S_DATA;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = shift_q >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_next = '0;
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          baud_next  = '0;
          state_next = S_STOP;
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_next   = '0;
            state_next = fifo_r_empty ? S_IDLE : S_FETCH;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          baud_next = baud_cnt + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the values the state will hold next cycle.
    tx_next = 1'b1;
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_next = parity_q;
`endif
      default:  tx_next = 1'b1;
    endcase

    frame_done_next = (state_next == S_STOP) && (baud_next == BAUD_LAST) &&
                      (bit_next == STOP_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_r_en  <= 1'b0;
      frame_done <= 1'b0;
    end else if (clk_en) begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_q    <= shift_next;
      tx         <= tx_next;
      busy       <= (state_next != S_IDLE);
      fifo_r_en  <= (state_next == S_FETCH);
      frame_done <= frame_done_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else if (clk_en && (state == S_LOAD)) begin
      parity_q <= ^fifo_r_data;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, 8 data bits, 1 stop bit.
// Frame expectations adapt when UART_TX_PARITY_EN is defined.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b1;
  logic       fifo_r_empty;
  logic [7:0] fifo_r_data = '0;
  logic       fifo_r_en, tx, busy, frame_done;

  logic [7:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int checks = 0;
  int failures = 0;
  int en_cycles = 0;
  int done_pulses = 0;
  int en_while_empty = 0;

  fifo_uart_tx #(
    .DATA_WIDTH  (8),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .fifo_r_empty(fifo_r_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_r_en   (fifo_r_en),
    .tx          (tx),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after an enabled pop, gated by the shared clk_en.
  assign fifo_r_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (clk_en && fifo_r_en && !fifo_r_empty) begin
      fifo_r_data <= mem[rd_ptr % 16];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (reset && clk_en) begin
      if (fifo_r_en === 1'b1) en_cycles++;
      if (frame_done === 1'b1) done_pulses++;
      if (fifo_r_en === 1'b1 && fifo_r_empty) en_while_empty++;
    end
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr % 16] = d;
    wr_ptr++;
  endtask

  // Waits for a start bit, then compares every cycle of the frame against the expected bit levels.
  // stretch_bit is the frame bit index (0 = start) lengthened by stretch_len cycles; -1 for none.
  task automatic capture_frame(input string tag, input logic [7:0] byte_in,
                               input int stretch_bit, input int stretch_len,
                               input int exp_idle, output logic par_out);
    int   durs [12];
    logic lvl  [12];
    int   nbits, idle, total, bad, done_cycle, done_count;
    logic [7:0] decoded;
    nbits   = 10 + PAR;
    decoded = '0;
    par_out = 1'bx;
    lvl[0]  = 1'b0;
    for (int i = 0; i < 8; i++) lvl[i+1] = byte_in[i];
    if (PAR == 1) lvl[9] = ^byte_in;
    lvl[nbits-1] = 1'b1;
    for (int k = 0; k < nbits; k++) durs[k] = (k == stretch_bit) ? CPB + stretch_len : CPB;

    idle = 0;
    @(negedge clk);
    while (tx !== 1'b0 && idle < 40) begin
      idle++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (exp_idle >= 0) check({tag, "_gap"}, idle, exp_idle);

    bad = 0; done_cycle = 0; done_count = 0; total = 0;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < durs[k]; c++) begin
        if (total > 0) @(negedge clk);
        total++;
        if (tx !== lvl[k] || busy !== 1'b1) bad++;
        if (c == 1 && k >= 1 && k <= 8) decoded[k-1] = tx;
        if (c == 1 && PAR == 1 && k == 9) par_out = tx;
        if (frame_done === 1'b1) begin
          done_count++;
          if (done_cycle == 0) done_cycle = total;
        end
      end
    end
    check({tag, "_levels"}, bad, 0);
    check({tag, "_byte"}, decoded, byte_in);
    check({tag, "_done_cycle"}, done_cycle, (10 + PAR) * CPB + stretch_len);
    check({tag, "_done_count"}, done_count, 1);
  endtask

  initial begin
    int   bad, n, e0, d0;
    logic par;

    // 1: reset held low with a non-empty FIFO
    push(8'hA5);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("t1_reset_hold", bad, 0);
    reset = 1'b1;
    @(negedge clk);
    check("t1_first_en", fifo_r_en, 1'b1);

    // 2: single 0xA5 frame
    capture_frame("t2", 8'hA5, -1, 0, -1, par);
    @(negedge clk);
    check("t2_en_count", en_cycles, 1);
    check("t2_done_count", done_pulses, 1);
    check("t2_busy_low", busy, 1'b0);
    check("t2_done_low", frame_done, 1'b0);

    // 3: three back-to-back frames
    e0 = en_cycles; d0 = done_pulses;
    push(8'd15); push(8'd69); push(8'd42);
    capture_frame("t3a", 8'd15, -1, 0, 2, par);
    capture_frame("t3b", 8'd69, -1, 0, 2, par);
    capture_frame("t3c", 8'd42, -1, 0, 2, par);
    @(negedge clk);
    check("t3_en_count", en_cycles - e0, 3);
    check("t3_done_count", done_pulses - d0, 3);
    check("t3_idle", busy, 1'b0);
    check("t3_empty", fifo_r_empty, 1'b1);

    // 4: clk_en low for 7 cycles in the middle of data bit 2 (frame bit 3)
    push(8'h3C);
    fork
      capture_frame("t4", 8'h3C, 3, 7, 2, par);
      begin
        n = 0;
        @(negedge clk);
        while (tx !== 1'b0 && n < 40) begin
          n++;
          @(negedge clk);
        end
        repeat (13) @(negedge clk);
        clk_en = 1'b0;
        repeat (7) @(negedge clk);
        clk_en = 1'b1;
      end
    join

    // 5: reset pulsed during data bit 3 of 0x52 (bit 3 is 0, so tx is low beforehand)
    @(negedge clk);
    e0 = en_cycles; d0 = done_pulses;
    push(8'h52);
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    repeat (17) @(negedge clk);
    check("t5_tx_before", tx, 1'b0);
    reset = 1'b0;
    #1;
    check("t5_tx_reset", tx, 1'b1);
    check("t5_busy_reset", busy, 1'b0);
    check("t5_en_reset", fifo_r_en, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_r_en !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("t5_quiet_after", bad, 0);
    check("t5_en_count", en_cycles - e0, 1);
    check("t5_done_count", done_pulses - d0, 0);

`ifdef UART_TX_PARITY_EN
    // 6: even parity bit
    push(8'hA5); push(8'h07);
    capture_frame("t6a", 8'hA5, -1, 0, 2, par);
    check("t6_par_a5", par, 1'b0);
    capture_frame("t6b", 8'h07, -1, 0, 2, par);
    check("t6_par_07", par, 1'b1);
    @(negedge clk);
`endif

    check("all_popped", rd_ptr, 6 + 2 * PAR);
    check("en_while_empty", en_while_empty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
